// File: rtl/dyn_pattern_seq_ctrl.sv
// Sequencing controller for a serial BITS-wide pattern detector: takes patterns and
// parallel words over valid/ready, serialises words MSB-first, counts detector matches.
module dyn_pattern_seq_ctrl #(
    parameter int unsigned BITS  = 5,
    parameter int unsigned WORD  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [BITS-1:0]  cfg_pattern,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [WORD-1:0]  word_data,
    output logic             det_rst,
    output logic             det_valid,
    output logic             det_in,
    output logic [BITS-1:0]  det_pattern,
    input  logic             det_out,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    input  logic             clr_count,
    output logic             busy
);
    localparam int unsigned IDX_W = (WORD > 1) ? $clog2(WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_loaded, w_loaded_nxt;
    logic [BITS-1:0]  r_pattern, w_pattern_nxt;
    logic [WORD-1:0]  r_shreg, w_shreg_nxt;
    logic [IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
    logic             r_match_pulse;
    logic [CNT_W-1:0] r_match_count;
    logic             w_last_bit;
    logic             w_word_acc;

    assign w_last_bit = (r_bit_idx == LAST_IDX);
    // A pending configuration always blocks a word in IDLE.
    assign word_ready = r_loaded &&
                        (((r_state == ST_IDLE) && !cfg_valid) ||
                         ((r_state == ST_SHIFT) && w_last_bit));
    assign w_word_acc = word_ready && word_valid;

    assign cfg_ready   = (r_state == ST_IDLE);
    assign det_rst     = rst || (r_state == ST_CLEAR);
    assign det_valid   = (r_state == ST_SHIFT);
    assign det_in      = r_shreg[WORD-1];
    assign det_pattern = r_pattern;
    assign busy        = (r_state != ST_IDLE);
    assign match_pulse = r_match_pulse;
    assign match_count = r_match_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_loaded  <= 1'b0;
            r_pattern <= '0;
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_loaded  <= w_loaded_nxt;
            r_pattern <= w_pattern_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_loaded_nxt  = r_loaded;
        w_pattern_nxt = r_pattern;
        w_shreg_nxt   = r_shreg;
        w_bit_idx_nxt = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_pattern_nxt = cfg_pattern;
                    w_loaded_nxt  = 1'b1;
                    w_state_nxt   = ST_CLEAR;
                end else if (w_word_acc) begin
                    w_shreg_nxt   = word_data;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_CLEAR: w_state_nxt = ST_IDLE;
            ST_SHIFT: begin
                w_shreg_nxt   = {r_shreg[WORD-2:0], 1'b0};
                w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                // Reloading on the last bit keeps det_valid high across words.
                if (w_last_bit) begin
                    w_bit_idx_nxt = '0;
                    if (w_word_acc) begin
                        w_shreg_nxt = word_data;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Match counter: clear wins over an increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_pulse <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_match_pulse <= det_out;
            if (clr_count) begin
                r_match_count <= '0;
            end else if (det_out && (r_match_count != {CNT_W{1'b1}})) begin
                r_match_count <= r_match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dyn_pattern_seq_ctrl.sv
// Bench for dyn_pattern_seq_ctrl: a behavioural detector drives det_out, and a bit-stream
// reference model predicts match counts for a 16-bit and a 2-bit counter instance.
module tb_dyn_pattern_seq_ctrl;
    localparam int unsigned BITS = 5;
    localparam int unsigned WORD = 8;

    logic            clk = 1'b0;
    logic            rst, cfg_valid, word_valid, clr_count, det_out;
    logic [BITS-1:0] cfg_pattern;
    logic [WORD-1:0] word_data;
    logic            cfg_ready, word_ready, det_rst, det_valid, det_in, match_pulse, busy;
    logic [BITS-1:0] det_pattern;
    logic [15:0]     match_count;
    logic            s_cfg_ready, s_word_ready, s_det_rst, s_det_valid, s_det_in, s_match_pulse, s_busy;
    logic [BITS-1:0] s_det_pattern;
    logic [1:0]      s_match_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dyn_pattern_seq_ctrl #(.BITS(BITS), .WORD(WORD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .det_rst(det_rst), .det_valid(det_valid), .det_in(det_in), .det_pattern(det_pattern),
        .det_out(det_out), .match_pulse(match_pulse), .match_count(match_count),
        .clr_count(clr_count), .busy(busy));

    dyn_pattern_seq_ctrl #(.BITS(BITS), .WORD(WORD), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready), .cfg_pattern(cfg_pattern),
        .word_valid(word_valid), .word_ready(s_word_ready), .word_data(word_data),
        .det_rst(s_det_rst), .det_valid(s_det_valid), .det_in(s_det_in), .det_pattern(s_det_pattern),
        .det_out(det_out), .match_pulse(s_match_pulse), .match_count(s_match_count),
        .clr_count(clr_count), .busy(s_busy));

    // Behavioural detector: registered match once BITS valid bits have been seen.
    logic [BITS-1:0] d_hist;
    int              d_fill;
    always @(posedge clk) begin
        if (det_rst) begin
            d_hist  <= '0;
            d_fill  <= 0;
            det_out <= 1'b0;
        end else begin
            det_out <= 1'b0;
            if (det_valid) begin
                d_hist <= {d_hist[BITS-2:0], det_in};
                if (d_fill < BITS) d_fill <= d_fill + 1;
                det_out <= (d_fill >= BITS - 1) && ({d_hist[BITS-2:0], det_in} == det_pattern);
            end
        end
    end

    // Cycle monitor sampled away from the active edge.
    int cyc = 0;
    int mon_vcyc[$];
    bit mon_bits[$];
    int mon_pcyc[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (det_valid) begin
            mon_vcyc.push_back(cyc);
            mon_bits.push_back(det_in);
        end
        if (match_pulse) mon_pcyc.push_back(cyc);
    end

    // Reference model: the bit stream since the last pattern load, windows compared directly.
    bit [BITS-1:0] ref_pat;
    bit            ref_hist[$];
    int unsigned   ref_count;

    function automatic void ref_config(input bit [BITS-1:0] p);
        ref_pat = p;
        ref_hist.delete();
    endfunction

    function automatic void ref_word(input bit [WORD-1:0] w);
        bit [BITS-1:0] win;
        for (int i = WORD - 1; i >= 0; i--) begin
            ref_hist.push_back(w[i]);
            if (ref_hist.size() >= BITS) begin
                for (int k = 0; k < BITS; k++) win[BITS-1-k] = ref_hist[ref_hist.size() - BITS + k];
                if (win == ref_pat) ref_count++;
            end
        end
    endfunction

    function automatic int unsigned ref_small();
        return (ref_count > 3) ? 3 : ref_count;
    endfunction

    task automatic mon_clear();
        mon_vcyc.delete();
        mon_bits.delete();
        mon_pcyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; word_valid = 1'b0; clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ref_count = 0;
        ref_hist.delete();
    endtask

    task automatic load_pattern(input logic [BITS-1:0] p);
        bit ok = 0;
        cfg_valid = 1'b1; cfg_pattern = p;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL cfg_accept got=0 exp=1"); end
        if (ok) ref_config(p);
    endtask

    task automatic send_word(input logic [WORD-1:0] w);
        bit ok = 0;
        word_valid = 1'b1; word_data = w;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (word_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1 word_valid = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL word_accept got=0 exp=1"); end
        if (ok) ref_word(w);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_timeout busy=%0b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; word_valid = 1'b0; clr_count = 1'b0; cfg_pattern = '0; word_data = '0;
        @(negedge clk);
        checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL rst_det_rst got=%0b exp=1", det_rst); end
        do_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || s_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b/%0b exp=0", busy, s_busy); end
        checks++; if (cfg_ready !== 1'b1 || s_cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%0b/%0b exp=1", cfg_ready, s_cfg_ready); end
        checks++; if (word_ready !== 1'b0 || s_word_ready !== 1'b0) begin failures++; $display("FAIL rst_word_ready got=%0b/%0b exp=0", word_ready, s_word_ready); end
        checks++; if (det_valid !== 1'b0 || s_det_valid !== 1'b0 || det_in !== 1'b0 || s_det_in !== 1'b0) begin failures++; $display("FAIL rst_det_valid got=%0b%0b%0b%0b exp=0000", det_valid, s_det_valid, det_in, s_det_in); end
        checks++; if (det_rst !== 1'b0 || s_det_rst !== 1'b0) begin failures++; $display("FAIL rst_det_rst_low got=%0b/%0b exp=0", det_rst, s_det_rst); end
        checks++; if (det_pattern !== '0 || s_det_pattern !== '0) begin failures++; $display("FAIL rst_pattern got=%0h/%0h exp=0", det_pattern, s_det_pattern); end
        checks++; if (match_count !== 16'd0 || s_match_count !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d/%0d exp=0", match_count, s_match_count); end
        checks++; if (match_pulse !== 1'b0 || s_match_pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse got=%0b/%0b exp=0", match_pulse, s_match_pulse); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        bit exp_bits[$] = '{1, 0, 1, 1, 0, 0, 0, 0};
        do_reset();
        load_pattern(5'b10110);
        mon_clear();
        send_word(8'b10110000);
        wait_idle();
        checks++; if (mon_bits.size() != 8) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=8", mon_bits.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (mon_bits[i] != exp_bits[i]) begin failures++; $display("FAIL single_bit%0d got=%0b exp=%0b", i, mon_bits[i], exp_bits[i]); end
            end
            checks++; if (mon_vcyc[7] - mon_vcyc[0] != 7) begin failures++; $display("FAIL single_contig got=%0d exp=7", mon_vcyc[7] - mon_vcyc[0]); end
        end
        checks++; if (mon_pcyc.size() != 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", mon_pcyc.size()); end
        else if (mon_vcyc.size() == 8) begin
            checks++; if (mon_pcyc[0] != mon_vcyc[4] + 2) begin failures++; $display("FAIL single_pulse_time got=%0d exp=%0d", mon_pcyc[0], mon_vcyc[4] + 2); end
        end
        checks++; if (match_count !== 16'(ref_count) || ref_count != 1) begin failures++; $display("FAIL single_count got=%0d exp=%0d", match_count, ref_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_pattern(5'b11111);
        mon_clear();
        send_word(8'b00000111);
        send_word(8'b11000000);
        wait_idle();
        checks++; if (mon_vcyc.size() != 16) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=16", mon_vcyc.size()); end
        else begin
            checks++; if (mon_vcyc[15] - mon_vcyc[0] != 15) begin failures++; $display("FAIL b2b_contig got=%0d exp=15", mon_vcyc[15] - mon_vcyc[0]); end
            checks++; if (mon_pcyc.size() != 1) begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", mon_pcyc.size()); end
            else begin
                checks++; if (mon_pcyc[0] != mon_vcyc[9] + 2) begin failures++; $display("FAIL b2b_pulse_time got=%0d exp=%0d", mon_pcyc[0], mon_vcyc[9] + 2); end
            end
        end
        checks++; if (match_count !== 16'(ref_count) || ref_count != 1) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", match_count, ref_count); end
    endtask

    task automatic test_no_pattern();
        do_reset();
        mon_clear();
        word_valid = 1'b1; word_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (word_ready !== 1'b0 || det_valid !== 1'b0) begin failures++; $display("FAIL unloaded_c%0d ready=%0b valid=%0b exp=0", i, word_ready, det_valid); end
        end
        @(posedge clk);
        #1 cfg_valid = 1'b1; cfg_pattern = 5'b11111;
        @(negedge clk);
        checks++; if (word_ready !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL unloaded_cfg ready=%0b cfg_ready=%0b exp=0/1", word_ready, cfg_ready); end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        ref_config(5'b11111);
        @(negedge clk);
        checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL unloaded_clear got=%0b exp=1", det_rst); end
        @(negedge clk);
        checks++; if (det_rst !== 1'b0 || word_ready !== 1'b1) begin failures++; $display("FAIL unloaded_accept rst=%0b ready=%0b exp=0/1", det_rst, word_ready); end
        @(posedge clk);
        #1 word_valid = 1'b0;
        ref_word(8'hFF);
        wait_idle();
        checks++; if (mon_vcyc.size() != 8) begin failures++; $display("FAIL unloaded_cycles got=%0d exp=8", mon_vcyc.size()); end
        checks++; if (match_count !== 16'(ref_count)) begin failures++; $display("FAIL unloaded_count got=%0d exp=%0d", match_count, ref_count); end
    endtask

    task automatic test_pattern_change();
        bit got = 0;
        int rst_seen = 0;
        do_reset();
        load_pattern(5'b10101);
        mon_clear();
        send_word(8'hAA);
        cfg_valid = 1'b1; cfg_pattern = 5'b00000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_ready) begin got = 1; break; end
            if (det_rst) rst_seen++;
        end
        checks++; if (!got || rst_seen != 0) begin failures++; $display("FAIL chg_wait got=%0b early_rst=%0d exp=1/0", got, rst_seen); end
        checks++; if (mon_vcyc.size() != 8) begin failures++; $display("FAIL chg_drained got=%0d exp=8", mon_vcyc.size()); end
        checks++; if (det_pattern !== 5'b10101) begin failures++; $display("FAIL chg_old_pattern got=%0b exp=10101", det_pattern); end
        checks++; if (match_count !== 16'(ref_count) || ref_count != 2) begin failures++; $display("FAIL chg_count_before got=%0d exp=%0d", match_count, ref_count); end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        ref_config(5'b00000);
        rst_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (det_rst) rst_seen++;
        end
        checks++; if (rst_seen != 1) begin failures++; $display("FAIL chg_det_rst_cycles got=%0d exp=1", rst_seen); end
        checks++; if (det_pattern !== 5'b00000) begin failures++; $display("FAIL chg_new_pattern got=%0b exp=00000", det_pattern); end
        checks++; if (match_count !== 16'd2) begin failures++; $display("FAIL chg_count_after got=%0d exp=2", match_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        bit got = 0;
        do_reset();
        load_pattern(5'b11111);
        for (int k = 1; k <= 5; k++) begin
            send_word(8'b00011111);
            wait_idle();
            checks++; if (s_match_count !== 2'(ref_small())) begin failures++; $display("FAIL sat_small%0d got=%0d exp=%0d", k, s_match_count, ref_small()); end
            checks++; if (match_count !== 16'(ref_count)) begin failures++; $display("FAIL sat_big%0d got=%0d exp=%0d", k, match_count, ref_count); end
        end
        send_word(8'b00011111);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (det_out) begin got = 1; break; end
        end
        clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        ref_count = 0;
        @(negedge clk);
        checks++; if (!got) begin failures++; $display("FAIL clr_det_out_timeout got=0 exp=1"); end
        checks++; if (s_match_count !== 2'd0 || match_count !== 16'd0) begin failures++; $display("FAIL clr_count got=%0d/%0d exp=0", s_match_count, match_count); end
        checks++; if (s_match_pulse !== 1'b1 || match_pulse !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%0b/%0b exp=1", s_match_pulse, match_pulse); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_pattern(5'b10110);
        mon_clear();
        send_word(8'b10110000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; word_valid = 1'b1; word_data = 8'hB0;
        @(negedge clk);
        checks++; if (det_rst !== 1'b1) begin failures++; $display("FAIL mid_det_rst got=%0b exp=1", det_rst); end
        @(posedge clk);
        #1 rst = 1'b0;
        ref_count = 0;
        ref_hist.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (det_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || word_ready !== 1'b0)
                begin failures++; $display("FAIL mid_after%0d valid=%0b busy=%0b cfg_ready=%0b word_ready=%0b exp=0010", i, det_valid, busy, cfg_ready, word_ready); end
        end
        checks++; if (match_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", match_count); end
        @(posedge clk);
        #1 word_valid = 1'b0;
        load_pattern(5'b10110);
        send_word(8'b10110000);
        wait_idle();
        checks++; if (mon_vcyc.size() != 12) begin failures++; $display("FAIL mid_valid_cycles got=%0d exp=12", mon_vcyc.size()); end
        checks++; if (match_count !== 16'(ref_count) || ref_count != 1) begin failures++; $display("FAIL mid_final_count got=%0d exp=%0d", match_count, ref_count); end
    endtask

    task automatic test_random();
        int nwords;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            wait_idle();
            load_pattern(BITS'($urandom_range(0, 31)));
            mon_clear();
            nwords = 0;
            for (int w = 0; w < 6; w++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wait_idle();
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                send_word(WORD'($urandom));
                nwords++;
            end
            wait_idle();
            checks++; if (mon_vcyc.size() != nwords * WORD) begin failures++; $display("FAIL rand%0d_cycles got=%0d exp=%0d", r, mon_vcyc.size(), nwords * WORD); end
            checks++; if (match_count !== 16'(ref_count)) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, match_count, ref_count); end
            checks++; if (s_match_count !== 2'(ref_small())) begin failures++; $display("FAIL rand%0d_small got=%0d exp=%0d", r, s_match_count, ref_small()); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_no_pattern();
        test_pattern_change();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
